// File: rtl/h14tx_pkg.sv
// Shared types and default timing for the TMDS PLL lock controller.
package h14tx_pkg;

   typedef enum logic [2:0] {
      PllReset,
      WaitLock,
      Debounce,
      Locked,
      Failed
   } lock_state_t;

   localparam int unsigned DEF_RESET_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT    = 1024;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 64;
   localparam int unsigned DEF_RETRY_W         = 4;
   localparam int unsigned DEF_MAX_RETRIES     = 8;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/h14tx_sync_bit.sv
// Two-flop synchroniser for level signals crossing into clk; resets to 0.
module h14tx_sync_bit #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/h14tx_pll_lock_ctrl.sv
// TMDS PLL reset sequencing and lock qualification on the reference clock.
// Define H14TX_LOCK_RETRY_LIMIT_EN to stop retrying after MAX_RETRIES timeouts.
module h14tx_pll_lock_ctrl
   import h14tx_pkg::*;
#(
   parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
   parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned RETRY_W         = DEF_RETRY_W,
   parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pll_lock_raw,
   input  logic               force_relock,
   input  logic               clr_status,
   output logic               pll_rst,
   output logic               lock,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_count,
   output logic               fail
);

   localparam int unsigned CNT_W = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, DEBOUNCE_CYCLES));

   if (RESET_CYCLES < 2 || LOCK_TIMEOUT < 2 || DEBOUNCE_CYCLES < 2 || MAX_RETRIES < 1)
   begin : g_bad_params
      $error("h14tx_pll_lock_ctrl: timing parameters must be >= 2, MAX_RETRIES >= 1");
   end

   lock_state_t        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [RETRY_W-1:0] retry_next;
   logic               lock_s;
   logic               timeout;
   logic               loss;
   logic               retry_clr;

   h14tx_sync_bit #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock_raw),
      .q     (lock_s)
   );

   always_comb begin
      state_d    = state_q;
      timeout    = 1'b0;
      loss       = 1'b0;
      retry_clr  = 1'b0;
      retry_next = (retry_count == '1) ? retry_count : retry_count + 1'b1;

      if (force_relock && state_q != PllReset) begin
         state_d = PllReset;
`ifdef H14TX_LOCK_RETRY_LIMIT_EN
         retry_clr = (state_q == Failed);
`endif
      end else begin
         unique case (state_q)
            PllReset: begin
               if (cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = WaitLock;
            end
            WaitLock: begin
               // A lock arriving on the timeout cycle takes precedence over the retry.
               if (lock_s) begin
                  state_d = Debounce;
               end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  timeout = 1'b1;
                  state_d = PllReset;
`ifdef H14TX_LOCK_RETRY_LIMIT_EN
                  if (retry_next == RETRY_W'(MAX_RETRIES)) state_d = Failed;
`endif
               end
            end
            Debounce: begin
               if (!lock_s) begin
                  state_d = WaitLock;
               end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  state_d = Locked;
               end
            end
            Locked: begin
               if (!lock_s) begin
                  loss    = 1'b1;
                  state_d = PllReset;
               end
            end
            Failed: begin
`ifndef H14TX_LOCK_RETRY_LIMIT_EN
               state_d = PllReset;
`endif
            end
            default: state_d = PllReset;
         endcase
      end
   end

   // Outputs are registered from the next state so they change with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PllReset;
         cnt_q       <= '0;
         pll_rst     <= 1'b1;
         lock        <= 1'b0;
         lock_lost   <= 1'b0;
         retry_count <= '0;
`ifdef H14TX_LOCK_RETRY_LIMIT_EN
         fail        <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
         pll_rst <= (state_d == PllReset) || (state_d == Failed);
         lock    <= (state_d == Locked);
         if (loss) begin
            lock_lost <= 1'b1;
         end else if (clr_status) begin
            lock_lost <= 1'b0;
         end
         if (retry_clr) begin
            retry_count <= '0;
         end else if (timeout) begin
            retry_count <= retry_next;
         end
`ifdef H14TX_LOCK_RETRY_LIMIT_EN
         fail <= (state_d == Failed);
`endif
      end
   end

`ifndef H14TX_LOCK_RETRY_LIMIT_EN
   assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_h14tx_pll_lock_ctrl.sv
// Directed table-driven bench for h14tx_pll_lock_ctrl (RESET=4, TIMEOUT=16, DEBOUNCE=8).
module tb_h14tx_pll_lock_ctrl;

`ifdef H14TX_LOCK_RETRY_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock_raw;
   logic       force_relock;
   logic       clr_status;
   logic       pll_rst;
   logic       lock;
   logic       lock_lost;
   logic [3:0] retry_count;
   logic       fail;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       raw;
      logic       frc;
      logic       clr;
      int         cyc;
      logic       e_rst;
      logic       e_lock;
      logic       e_lost;
      logic [3:0] e_rc;
      logic       e_fail;
   } vec_t;

   vec_t vecs[$];

   h14tx_pll_lock_ctrl #(
      .RESET_CYCLES    (4),
      .LOCK_TIMEOUT    (16),
      .DEBOUNCE_CYCLES (8),
      .RETRY_W         (4),
      .MAX_RETRIES     (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_lock_raw (pll_lock_raw),
      .force_relock (force_relock),
      .clr_status   (clr_status),
      .pll_rst      (pll_rst),
      .lock         (lock),
      .lock_lost    (lock_lost),
      .retry_count  (retry_count),
      .fail         (fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [7:0] got,
                        input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, got, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic e_rst, input logic e_lock,
                            input logic e_lost, input logic [3:0] e_rc, input logic e_fail);
      check("pll_rst", idx, {7'b0, pll_rst}, {7'b0, e_rst});
      check("lock", idx, {7'b0, lock}, {7'b0, e_lock});
      check("lock_lost", idx, {7'b0, lock_lost}, {7'b0, e_lost});
      check("retry_count", idx, {4'b0, retry_count}, {4'b0, e_rc});
      check("fail", idx, {7'b0, fail}, {7'b0, e_fail});
   endtask

   task automatic add(input logic raw, input logic frc, input logic clr, input int cyc,
                      input logic e_rst, input logic e_lock, input logic e_lost,
                      input logic [3:0] e_rc, input logic e_fail);
      vec_t v;
      v.raw = raw; v.frc = frc; v.clr = clr; v.cyc = cyc;
      v.e_rst = e_rst; v.e_lock = e_lock; v.e_lost = e_lost; v.e_rc = e_rc; v.e_fail = e_fail;
      vecs.push_back(v);
   endtask

   initial begin
      logic [3:0] rc_end;
      rc_end = LIMIT_EN ? 4'd0 : 4'd2;

      // raw, frc, clr, cycles | pll_rst, lock, lock_lost, retry_count, fail
      // Power-up with raw lock high: 4 reset cycles, 1 WaitLock, 8 Debounce.
      add(1, 0, 0,  3,  1, 0, 0, 0, 0);
      add(1, 0, 0,  1,  0, 0, 0, 0, 0);
      add(1, 0, 0,  8,  0, 0, 0, 0, 0);
      add(1, 0, 0,  1,  0, 1, 0, 0, 0);
      add(1, 0, 0,  5,  0, 1, 0, 0, 0);
      // One-cycle raw drop: lock falls two edges after it is sampled.
      add(0, 0, 0,  1,  0, 1, 0, 0, 0);
      add(1, 0, 0,  1,  0, 1, 0, 0, 0);
      add(1, 0, 0,  1,  1, 0, 1, 0, 0);
      add(1, 0, 0,  3,  1, 0, 1, 0, 0);
      add(1, 0, 0,  1,  0, 0, 1, 0, 0);
      add(1, 0, 0,  8,  0, 0, 1, 0, 0);
      add(1, 0, 0,  1,  0, 1, 1, 0, 0);
      add(1, 0, 1,  1,  0, 1, 0, 0, 0);
      // clr_status on the same edge as a new loss: set wins.
      add(0, 0, 0,  1,  0, 1, 0, 0, 0);
      add(1, 0, 0,  1,  0, 1, 0, 0, 0);
      add(1, 0, 1,  1,  1, 0, 1, 0, 0);
      add(1, 0, 0, 12,  0, 0, 1, 0, 0);
      add(1, 0, 0,  1,  0, 1, 1, 0, 0);
      // force_relock from Locked.
      add(1, 1, 0,  1,  1, 0, 1, 0, 0);
      add(1, 0, 0, 12,  0, 0, 1, 0, 0);
      add(1, 0, 0,  1,  0, 1, 1, 0, 0);
      // Relock with raw low, 3-cycle glitch, then the timeout restarts from WaitLock re-entry.
      add(0, 1, 0,  1,  1, 0, 1, 0, 0);
      add(0, 0, 0,  4,  0, 0, 1, 0, 0);
      add(1, 0, 0,  3,  0, 0, 1, 0, 0);
      add(0, 0, 0,  3,  0, 0, 1, 0, 0);
      add(0, 0, 0, 15,  0, 0, 1, 0, 0);
      add(0, 0, 0,  1,  1, 0, 1, 1, 0);
      add(0, 0, 0,  3,  1, 0, 1, 1, 0);
      add(0, 0, 0,  1,  0, 0, 1, 1, 0);
      add(0, 0, 0, 15,  0, 0, 1, 1, 0);
      add(0, 0, 0,  1,  1, 0, 1, 2, LIMIT_EN);
      add(0, 0, 0,  4,  LIMIT_EN, 0, 1, 2, LIMIT_EN);
      add(1, 0, 0, 11,  LIMIT_EN, !LIMIT_EN, 1, 2, LIMIT_EN);
      add(1, 1, 0,  1,  1, 0, 1, rc_end, 0);
      add(1, 0, 0, 12,  0, 0, 1, rc_end, 0);
      add(1, 0, 0,  1,  0, 1, 1, rc_end, 0);

      rst_n        = 1'b0;
      pll_lock_raw = 1'b1;
      force_relock = 1'b0;
      clr_status   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all(-1, 1, 0, 0, 0, 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         pll_lock_raw = vecs[i].raw;
         force_relock = vecs[i].frc;
         clr_status   = vecs[i].clr;
         repeat (vecs[i].cyc) @(posedge clk);
         #1;
         check_all(i, vecs[i].e_rst, vecs[i].e_lock, vecs[i].e_lost, vecs[i].e_rc,
                   vecs[i].e_fail);
      end

      // Async reset in the middle of Debounce, checked before the next clock edge.
      pll_lock_raw = 1'b1;
      force_relock = 1'b1;
      clr_status   = 1'b0;
      @(posedge clk);
      #1;
      force_relock = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("debounce_pll_rst", 100, {7'b0, pll_rst}, 8'd0);
      check("debounce_lock", 100, {7'b0, lock}, 8'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all(101, 1, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all(102, 1, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
